// File: rtl/store_merge.sv
// Sub-word store engine: read-modify-write merge of byte/halfword stores into 32-bit memory words.
// Optional macro SS_ALIGN_CHECK_EN rejects misaligned half/word stores with a misalign pulse.
module store_merge (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  sscontrol,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam logic [1:0] SS_BYTE = 2'b00;
  localparam logic [1:0] SS_HALF = 2'b01;
  localparam logic [1:0] SS_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, WT, WR, DONE} state_t;

  state_t      state;
  logic [1:0]  ss_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        mis_c;

  // Replace the addressed byte or halfword lane of the old word with store data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] ss,
                                        input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (ss == SS_BYTE) r[{off, 3'b000} +: 8] = wd[7:0];
    else               r[{off[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

`ifdef SS_ALIGN_CHECK_EN
  assign mis_c = ((sscontrol == SS_HALF) && addr[0]) ||
                 ((sscontrol == SS_WORD) && (addr[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ss_q      <= 2'b00;
      off_q     <= 2'b00;
      wdata_q   <= 32'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ss_q     <= sscontrol;
            off_q    <= addr[1:0];
            wdata_q  <= wdata;
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            if (mis_c) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              case (sscontrol)
                SS_BYTE, SS_HALF: state <= RD;
                SS_WORD: begin
                  state     <= WR;
                  mem_wr    <= 1'b1;
                  mem_wdata <= wdata;
                end
                default: begin
                  state <= DONE;
                  done  <= 1'b1;
                end
              endcase
            end
          end
        end
        RD: state <= WT;
        WT: begin
          // Old word is registered directly in merged form as the write data.
          mem_wdata <= merge(mem_rdata, ss_q, off_q, wdata_q);
          mem_wr    <= 1'b1;
          state     <= WR;
        end
        WR: begin
          mem_wr <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          misalign <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Scoreboard bench for store_merge: byte-array reference model, sparse memory, randomized stores.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  sscontrol;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr, busy, done, misalign;

  always #5 clk = ~clk;

  store_merge dut (
    .clk(clk), .reset(reset), .start(start), .sscontrol(sscontrol), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .busy(busy), .done(done), .misalign(misalign)
  );

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          mis;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          wr_seen = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Memory environment: writes land on the clock, read data is presented from the held address.
  always @(posedge clk) begin
    cyc++;
    if (mem_wr === 1'b1) env_mem[mem_addr] = mem_wdata;
  end

  always @(negedge clk) mem_rdata = env_rd(mem_addr);

  // Monitor: matches observed writes and completions against queued expectations.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      checks++;
      if (q.size() == 0 || !q[0].wr || wr_seen) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_seen = 1;
        chk("write_addr", mem_addr, q[0].a);
        chk("write_data", mem_wdata, q[0].d);
      end
    end
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.done_cyc));
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("write_seen", 32'(wr_seen), 32'(e.wr));
        wr_seen = 0;
      end
    end else if (misalign === 1'b1) begin
      chk("misalign_without_done", 32'(misalign), 32'd0);
    end
  end

  // Reference model: expected write and latency, then drive the request with busy-time noise.
  task automatic issue(input logic [1:0] ss, input logic [31:0] a, input logic [31:0] wd,
                       input bit use_ovr, input logic [31:0] ovr);
    exp_t        e;
    logic [7:0]  b[4];
    logic [31:0] old;
    int          lat, n, base;
    bit          mis;
`ifdef SS_ALIGN_CHECK_EN
    mis = (ss == 2'd1 && a[0]) || (ss == 2'd2 && a[1:0] != 2'd0);
`else
    mis = 0;
`endif
    e.mis = mis;
    e.a   = a & 32'hFFFF_FFFC;
    e.d   = 32'h0;
    if (mis || ss == 2'd3) begin
      e.wr = 0;
      lat  = 1;
    end else if (ss == 2'd2) begin
      e.wr = 1;
      e.d  = wd;
      lat  = 2;
    end else begin
      e.wr = 1;
      lat  = 4;
      old  = ref_rd(e.a);
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      if (ss == 2'd0) begin
        b[a[1:0]] = wd[7:0];
      end else begin
        base = a[1] ? 2 : 0;
        b[base]     = wd[7:0];
        b[base + 1] = wd[15:8];
      end
      e.d = {b[3], b[2], b[1], b[0]};
    end
    if (use_ovr) e.d = ovr;
    if (e.wr) ref_mem[e.a] = e.d;
    e.done_cyc = cyc + lat;
    q.push_back(e);
    start = 1; sscontrol = ss; addr = a; wdata = wd;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 12) begin
      start = 1'($urandom_range(0, 1));
      sscontrol = 2'($urandom); addr = $urandom; wdata = $urandom;
      @(negedge clk);
      n++;
    end
    start = 0;
    if (busy !== 1'b0) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
    env_mem[a] = d;
    ref_mem[a] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; sscontrol = 0; addr = 0; wdata = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    reset = 0;
    @(negedge clk);

    set_mem(32'h100, 32'hAABBCCDD);
    set_mem(32'h200, 32'hAABBCCDD);
    issue(2'd0, 32'h102, 32'h0000_0011, 1, 32'hAA11CCDD);
    issue(2'd1, 32'h202, 32'h0000_1234, 1, 32'h1234CCDD);
    set_mem(32'h200, 32'hAABBCCDD);
    issue(2'd1, 32'h200, 32'h0000_1234, 1, 32'hAABB1234);
    issue(2'd2, 32'h40, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    issue(2'd2, 32'h41, 32'hCAFEF00D, 0, 32'h0);
    issue(2'd3, 32'h80, 32'h12345678, 0, 32'h0);

    // Reset while waiting on read data: the pending write must be dropped.
    start = 1; sscontrol = 2'd0; addr = 32'h300; wdata = 32'h55;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (6) @(negedge clk);

    // Reset and start together: nothing captured.
    reset = 1; start = 1; sscontrol = 2'd2; addr = 32'h500; wdata = 32'h99;
    @(negedge clk);
    reset = 0; start = 0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), 32'h1000 + 32'($urandom_range(0, 31)), $urandom, 0, 32'h0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data/address.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 sscontrol  input  2  store size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 addr  input  32  byte address of store.
REQ-008 wdata  input  32  register data to store; byte uses [7:0], half uses [15:0].
REQ-009 mem_rdata  input  32  memory read data, valid in the cycle after RD.
REQ-010 mem_addr  output  32  word address to memory, {addr_q[31:2],2'b00}.
REQ-011 mem_wdata  output  32  merged word to memory.
REQ-012 mem_wr  output  1  memory write enable, high only in WR.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 misalign  output  1  one-cycle alignment-error pulse, coincident with done.

Function
REQ-016 In IDLE with start=1, the block SHALL capture sscontrol, addr and wdata into internal registers; later input changes SHALL NOT affect the operation.
REQ-017 FSM states SHALL be IDLE, RD, WT, WR, DONE.
REQ-018 Transitions: byte/half IDLE->RD->WT->WR->DONE->IDLE; word IDLE->WR->DONE->IDLE; reserved 11 IDLE->DONE->IDLE with no memory access.
REQ-019 Latency from start edge to done: byte/half 4 cycles, word 2 cycles, reserved 1 cycle.
REQ-020 WT SHALL register mem_rdata as the old word; WR SHALL drive mem_wdata from that registered word.
REQ-021 Byte merge: lane k=addr_q[1:0], bits [8k+7:8k] replaced by wdata_q[7:0], other bits from old word.
REQ-022 Half merge: addr_q[1]=0 replaces [15:0], addr_q[1]=1 replaces [31:16] with wdata_q[15:0].
REQ-023 Word store SHALL write wdata_q unchanged without reading memory.
REQ-024 mem_addr SHALL be held stable from RD (or WR for word) through WR.
REQ-025 start while busy=1 SHALL be ignored and not queued.
REQ-026 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.
REQ-027 mem_wr SHALL be high for exactly one cycle per byte/half/word operation.

Reset
REQ-028 reset=1 SHALL force IDLE at the next edge from any state, including mid-operation, and abort any pending write.
REQ-029 Reset values: mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, misalign=0, internal registers 0.
REQ-030 If reset and start are both high, reset SHALL win and no request SHALL be captured.

Configuration
REQ-031 Macro SS_ALIGN_CHECK_EN: when defined, half with addr[0]=1 or word with addr[1:0]!=00 SHALL go IDLE->DONE with misalign=1 and done=1 in the same cycle, and SHALL NOT perform any memory access.
REQ-032 Without SS_ALIGN_CHECK_EN, misalign SHALL be tied 0, half SHALL ignore addr[0], and word SHALL ignore addr[1:0].

Verification
REQ-033 Byte store: mem_rdata=0xAABBCCDD, addr=0x102, wdata=0x11 -> mem_addr=0x100, mem_wdata=0xAA11CCDD, mem_wr 1 cycle, done at cycle 4.
REQ-034 Half store: mem_rdata=0xAABBCCDD, addr=0x202, wdata=0x1234 -> mem_wdata=0x1234CCDD; addr=0x200 -> 0xAABB1234.
REQ-035 Word store: addr=0x40, wdata=0xDEADBEEF -> no RD state, mem_wdata=0xDEADBEEF, done at cycle 2.
REQ-036 Reset in WT -> mem_wr never asserts, busy=0 next cycle; second start while busy -> only one write observed.
REQ-037 With SS_ALIGN_CHECK_EN, word addr=0x41 -> misalign=done=1 at cycle 1, mem_wr stays 0; without the macro, the same request writes at mem_addr 0x40.
